platform_field: RTL
===================

Name: platform_field

Overview:
- Owns the platform layout for the play field and closes the loop with the doodle block.
- Consumes doodle_x, doodle_y and doodle_fall_direction from the doodle block.
- Produces collision and ground for the doodle block, plus score and a lost pulse for game control.
- Scrolls the world when the doodle climbs past a line, respawns platforms at random x positions, and supplies per-pixel platform colour to the frame compositor.

Parameters:
FPS, 60, frame rate; sizes fps_counter.
CLK, 25000000, clock frequency in Hz; sizes fps_counter.
PLATFORM_COUNT, 8, number of platform slots.
PLATFORM_WIDTH, 114, platform width in pixels.
PLATFORM_HEIGHT, 30, landing band height in pixels, measured from the platform top.
FIELD_LEFT, 300, leftmost pixel column of the play field.
FIELD_WIDTH, 424, play field width in pixels.
SCROLL_LINE, 300, scrolling starts when doodle_y is above this line.
MAX_SCROLL, 16, maximum scroll in pixels per frame.
FLOOR_Y, 768, y of the initial floor.

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-low reset (0 = reset)
fps_counter  in  $clog2(CLK/FPS)+1  frame divider; all-ones marks the frame tick
game_state  in  2  1 = playing; any other value freezes the block
beam_x  in  11  current pixel column
beam_y  in  10  current pixel row
doodle_x  in  11  doodle top-left x
doodle_y  in  10  doodle top-left y
doodle_fall_direction  in  1  1 = doodle is falling
collision  out  1  doodle feet are on a platform or the floor this frame
ground  out  2x10  [0] = current ground top y; [1] = previous ground[0]
score  out  16  number of platforms respawned since reset
lost  out  1  one-cycle pulse when the doodle drops below the screen
color  out  3x4  platform RGB for the beam pixel
is_transparent  out  1  1 = no platform at the beam pixel

Behaviour:
- Reset (rst=0 at a clk edge):
  - platform i: y = FLOOR_Y - 96*(i+1); x = FIELD_LEFT + ((157*i) mod (FIELD_WIDTH - PLATFORM_WIDTH)).
  - floor_active = 1.
  - ground[0] = ground[1] = FLOOR_Y.
  - collision = 0, score = 0, lost = 0, is_transparent = 1, color = 0.
  - 9-bit LFSR seeded to 9'h1A5.
- Reset mid-frame restores this full state and takes priority over every other event.
- Frame tick: `&fps_counter` while game_state == 1. All position state changes only on a frame tick.
- Collision evaluation:
  - Registered on every clk from the current inputs. The doodle block only moves on a tick, so collision is stable by the next tick (latency 1 clk).
  - Define feet = doodle_y + 80.
  - Platform p is hit when all hold: doodle_fall_direction = 1; p.y <= feet < p.y + PLATFORM_HEIGHT; doodle_x + 20 < p.x + PLATFORM_WIDTH; doodle_x + 60 > p.x.
  - The floor is hit when floor_active = 1, doodle_fall_direction = 1 and feet >= FLOOR_Y - 1.
  - If several platforms are hit, the lowest index wins. A platform hit takes priority over the floor.
  - collision = 0 whenever game_state != 1.
- ground update, at a tick with collision = 1: ground[1] <= ground[0]; ground[0] <= hit y (FLOOR_Y for the floor).
- Scroll, at a tick with collision = 0, doodle_fall_direction = 0 and doodle_y < SCROLL_LINE:
  - amount s = min(SCROLL_LINE - doodle_y, MAX_SCROLL).
  - Every platform y and ground[0] increase by s. This shifts the doodle down through its ground-relative height.
  - floor_active clears on the first scroll.
  - No scroll occurs on a collision tick.
- Respawn, in the same tick, for each platform whose post-scroll y >= FLOOR_Y:
  - y <= post-scroll y - FLOOR_Y (wraps to the top band).
  - x <= FIELD_LEFT + r, where r = LFSR reduced below FIELD_WIDTH - PLATFORM_WIDTH by one conditional subtract.
  - LFSR advances once per respawned platform.
  - score increments by one per respawn and saturates at 16'hFFFF.
- Lost: at a tick with floor_active = 0, doodle_fall_direction = 1 and doodle_y > FLOOR_Y - 80, lost pulses high for exactly 1 clk. Platform state is unchanged.
- Width rules:
  - All y arithmetic is done at 11 bits before compare; no 10-bit wrap occurs inside a compare.
  - x compares are done at 12 bits.
- Rendering, registered with 1 clk latency:
  - If beam_x is in [p.x, p.x + PLATFORM_WIDTH) and beam_y is in [p.y, p.y + 16) for any p: color = {4'h5, 4'hB, 4'h2}, is_transparent = 0.
  - Otherwise is_transparent = 1 and color holds its value.
- Freeze: game_state != 1 freezes platforms, ground, score and LFSR. Rendering continues.

Test Plan:
- Reset: hold rst=0 for 3 clk, release -> ground = {768, 768}, platform 0 at (300, 672), score = 0, is_transparent = 1 after one clk.
- Land on platform: doodle (330, 592), falling, game_state = 1 -> collision = 1 next clk; at tick ground[0] = 672, ground[1] = 768.
- Horizontal miss and rising pass: doodle_x = 420 over platform 0 (right edge 414), falling -> collision = 0. Same position with fall_direction = 0 -> collision = 0.
- Scroll and respawn: doodle_y = 250, rising -> at tick platforms and ground[0] shift +16, floor_active = 0. Force a platform to y = 760 with a scroll of 16 -> platform y = 8, x within [300, 610), score increments by 1.
- Lost: floor inactive, doodle_y = 700, falling, at tick -> lost high for exactly 1 clk. Freeze: game_state = 2 -> no state change across 5 ticks.
- Render: beam at (310, 680) with platform 0 at (300, 672) -> next clk color = 5/B/2, is_transparent = 0. Beam at (310, 690) -> is_transparent = 1.

Source files
------------

// File: rtl/platform_field_if.sv
// Link between the doodle block and the platform field: the doodle
// position goes in, the landing result (collision and ground) comes back.
interface platform_field_if;
    logic [10:0]     doodle_x;
    logic [9:0]      doodle_y;
    logic            doodle_fall_direction;
    logic            collision;
    logic [1:0][9:0] ground;

    modport master (
        output doodle_x, doodle_y, doodle_fall_direction,
        input  collision, ground
    );
    modport slave (
        input  doodle_x, doodle_y, doodle_fall_direction,
        output collision, ground
    );
endinterface

// File: rtl/platform_field.sv
// Platform layout for the play field: landing detection, world scroll,
// platform respawn from a 9-bit LFSR (x^9 + x^5 + 1), score and pixel colour.
module platform_field #(
    parameter int FPS             = 60,
    parameter int CLK             = 25000000,
    parameter int PLATFORM_COUNT  = 8,
    parameter int PLATFORM_WIDTH  = 114,
    parameter int PLATFORM_HEIGHT = 30,
    parameter int FIELD_LEFT      = 300,
    parameter int FIELD_WIDTH     = 424,
    parameter int SCROLL_LINE     = 300,
    parameter int MAX_SCROLL      = 16,
    parameter int FLOOR_Y         = 768
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [$clog2(CLK/FPS):0] fps_counter,
    input  logic [1:0]               game_state,
    input  logic [10:0]              beam_x,
    input  logic [9:0]               beam_y,
    platform_field_if.slave          doodle,
    output logic [15:0]              score,
    output logic                     lost,
    output logic [2:0][3:0]          color,
    output logic                     is_transparent
);

    localparam int         X_RANGE   = FIELD_WIDTH - PLATFORM_WIDTH;
    localparam logic [8:0] LFSR_SEED = 9'h1A5;

    logic [10:0] plat_x [PLATFORM_COUNT];
    logic [10:0] plat_y [PLATFORM_COUNT];
    logic [10:0] x_next [PLATFORM_COUNT];
    logic [10:0] y_next [PLATFORM_COUNT];
    logic        floor_active;
    logic [8:0]  lfsr, lfsr_next;
    logic [15:0] score_next;
    logic [9:0]  hit_y, hit_y_comb;
    logic        hit, beam_hit;
    logic        playing, tick, do_scroll, do_lost;
    logic [10:0] doodle_y11, feet, scroll_dist, scroll_amt;
    logic [11:0] foot_left, foot_right;

    function automatic logic [8:0] lfsr_step(input logic [8:0] v);
        return {v[7:0], v[8] ^ v[4]};
    endfunction

    // One conditional subtract is enough: the LFSR never reaches 2*X_RANGE.
    function automatic logic [10:0] lfsr_offset(input logic [8:0] v);
        return ({1'b0, v} >= 10'(X_RANGE)) ? 11'({1'b0, v} - 10'(X_RANGE)) : 11'(v);
    endfunction

    assign playing     = (game_state == 2'd1);
    assign tick        = playing && (&fps_counter);
    assign doodle_y11  = {1'b0, doodle.doodle_y};
    assign feet        = doodle_y11 + 11'd80;
    assign foot_left   = {1'b0, doodle.doodle_x} + 12'd20;
    assign foot_right  = {1'b0, doodle.doodle_x} + 12'd60;
    assign scroll_dist = 11'(SCROLL_LINE) - doodle_y11;
    assign scroll_amt  = (scroll_dist > 11'(MAX_SCROLL)) ? 11'(MAX_SCROLL) : scroll_dist;
    assign do_scroll   = tick && !doodle.collision && !doodle.doodle_fall_direction &&
                         (doodle_y11 < 11'(SCROLL_LINE));
    assign do_lost     = tick && !floor_active && doodle.doodle_fall_direction &&
                         (doodle_y11 > 11'(FLOOR_Y - 80));

    // Downward scan so the lowest-index platform overrides both the floor and higher slots.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no latch is inferred.
        hit        = 1'b0;
        hit_y_comb = 10'(FLOOR_Y);
        if (playing && doodle.doodle_fall_direction) begin
            if (floor_active && (feet >= 11'(FLOOR_Y - 1)))
                hit = 1'b1;
            for (int p = PLATFORM_COUNT - 1; p >= 0; p--) begin
                if ((feet >= plat_y[p]) && (feet < plat_y[p] + 11'(PLATFORM_HEIGHT)) &&
                    (foot_left < {1'b0, plat_x[p]} + 12'(PLATFORM_WIDTH)) &&
                    (foot_right > {1'b0, plat_x[p]})) begin
                    hit        = 1'b1;
                    hit_y_comb = plat_y[p][9:0];
                end
            end
        end
    end

    // Scroll, then wrap any platform pushed past the floor back to the top band.
    always_comb begin
        lfsr_next  = lfsr;
        score_next = score;
        for (int p = 0; p < PLATFORM_COUNT; p++) begin
            x_next[p] = plat_x[p];
            y_next[p] = plat_y[p] + scroll_amt;
            if (y_next[p] >= 11'(FLOOR_Y)) begin
                y_next[p] = y_next[p] - 11'(FLOOR_Y);
                x_next[p] = 11'(FIELD_LEFT) + lfsr_offset(lfsr_next);
                lfsr_next = lfsr_step(lfsr_next);
                if (score_next != 16'hFFFF)
                    score_next = score_next + 16'd1;
            end
        end
    end

    always_comb begin
        beam_hit = 1'b0;
        for (int p = 0; p < PLATFORM_COUNT; p++) begin
            if (({1'b0, beam_x} >= {1'b0, plat_x[p]}) &&
                ({1'b0, beam_x} < {1'b0, plat_x[p]} + 12'(PLATFORM_WIDTH)) &&
                ({1'b0, beam_y} >= plat_y[p]) &&
                ({1'b0, beam_y} < plat_y[p] + 11'd16))
                beam_hit = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!rst) begin
            // NOTE: the platform table is a flop array, not a RAM, so it takes a reset value.
            for (int i = 0; i < PLATFORM_COUNT; i++) begin
                plat_y[i] <= 11'(FLOOR_Y - 96 * (i + 1));
                plat_x[i] <= 11'(FIELD_LEFT + (157 * i) % X_RANGE);
            end
            floor_active     <= 1'b1;
            lfsr             <= LFSR_SEED;
            score            <= 16'd0;
            hit_y            <= 10'(FLOOR_Y);
            doodle.collision <= 1'b0;
            doodle.ground    <= {2{10'(FLOOR_Y)}};
            lost             <= 1'b0;
            color            <= '0;
            is_transparent   <= 1'b1;
        end else begin
            doodle.collision <= hit;
            hit_y            <= hit_y_comb;
            lost             <= do_lost;

            if (tick && doodle.collision) begin
                doodle.ground[1] <= doodle.ground[0];
                doodle.ground[0] <= hit_y;
            end else if (do_scroll) begin
                doodle.ground[0] <= doodle.ground[0] + scroll_amt[9:0];
            end

            if (do_scroll) begin
                floor_active <= 1'b0;
                lfsr         <= lfsr_next;
                score        <= score_next;
                for (int p = 0; p < PLATFORM_COUNT; p++) begin
                    plat_x[p] <= x_next[p];
                    plat_y[p] <= y_next[p];
                end
            end

            if (beam_hit) begin
                color          <= {4'h5, 4'hB, 4'h2};
                is_transparent <= 1'b0;
            end else begin
                is_transparent <= 1'b1;
            end
        end
    end

endmodule
